// File: rtl/fft_energy_detector.sv
// fft_energy_detector
// Per-bin power (re^2 + im^2) of an FFT output stream, averaged over
// 2^avg_log2 frames in a per-bin accumulator RAM. Emits the averaged
// spectrum with threshold flags, and tracks per-period peak bin and detect.
// avg_log2/threshold are taken at period start and travel with each bin,
// so a period's tail still in the pipeline is never affected by the next
// period's settings.
module fft_energy_detector #(
  parameter int         FFT_LEN_LOG2 = 10,
  parameter int         ACC_WIDTH    = 40,
  parameter logic [7:0] SR_BASE      = 8'd40
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    set_stb_i,
  input  logic [7:0]              set_addr_i,
  input  logic [31:0]             set_data_i,
  input  logic                    strobe_in_i,
  input  logic [31:0]             xk_i,
  output logic                    strobe_out_o,
  output logic [31:0]             power_out_o,
  output logic [FFT_LEN_LOG2-1:0] bin_out_o,
  output logic                    above_thr_o,
  output logic                    frame_done_o,
  output logic                    detect_o,
  output logic [FFT_LEN_LOG2-1:0] peak_bin_o,
  output logic [31:0]             peak_power_o
);
  localparam int NBINS = 1 << FFT_LEN_LOG2;
  localparam logic [FFT_LEN_LOG2-1:0] BIN_LAST = {FFT_LEN_LOG2{1'b1}};
  localparam logic [FFT_LEN_LOG2-1:0] BIN_ZERO = '0;

  logic wr_avg, wr_thr, resync;
  assign wr_avg = set_stb_i && (set_addr_i == SR_BASE);
  assign wr_thr = set_stb_i && (set_addr_i == SR_BASE + 8'd1);
  assign resync = set_stb_i && (set_addr_i == SR_BASE + 8'd2);

  logic [3:0]  avg_sh_q;
  logic [31:0] thr_sh_q;

  // Shadow settings registers, written from the settings bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avg_sh_q <= 4'd0;
      thr_sh_q <= 32'd0;
    end else begin
      if (wr_avg) avg_sh_q <= (set_data_i[3:0] > 4'd8) ? 4'd8 : set_data_i[3:0];
      if (wr_thr) thr_sh_q <= set_data_i;
    end
  end

  logic [FFT_LEN_LOG2-1:0] bin_cnt_q, bin_cnt_d;
  logic [7:0]              frm_cnt_q, frm_cnt_d;
  logic [3:0]              avg_q, avg_d, avg_eff;
  logic [31:0]             thr_q, thr_d, thr_eff;
  logic [8:0]              frm_last;
  logic                    period_start, first_eff, last_eff;

  // Bin/frame counters and active settings; the settings in effect for a
  // period are the shadows if this strobe opens the period.
  always_comb begin
    period_start = (bin_cnt_q == BIN_ZERO) && (frm_cnt_q == 8'd0);
    avg_eff      = period_start ? avg_sh_q : avg_q;
    thr_eff      = period_start ? thr_sh_q : thr_q;
    frm_last     = (9'd1 << avg_eff) - 9'd1;
    first_eff    = (frm_cnt_q == 8'd0);
    last_eff     = ({1'b0, frm_cnt_q} == frm_last);
    bin_cnt_d    = bin_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    avg_d        = avg_q;
    thr_d        = thr_q;
    if (resync) begin
      bin_cnt_d = BIN_ZERO;
      frm_cnt_d = 8'd0;
      avg_d     = avg_sh_q;
      thr_d     = thr_sh_q;
    end else if (strobe_in_i) begin
      bin_cnt_d = bin_cnt_q + FFT_LEN_LOG2'(1);
      if (bin_cnt_q == BIN_LAST) frm_cnt_d = last_eff ? 8'd0 : frm_cnt_q + 8'd1;
      avg_d = avg_eff;
      thr_d = thr_eff;
    end
  end

  // Counter and active-settings registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_cnt_q <= BIN_ZERO;
      frm_cnt_q <= 8'd0;
      avg_q     <= 4'd0;
      thr_q     <= 32'd0;
    end else begin
      bin_cnt_q <= bin_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      avg_q     <= avg_d;
      thr_q     <= thr_d;
    end
  end

  logic                    s1_vld_q, s2_vld_q;
  logic signed [15:0]      s1_re_q, s1_im_q;
  logic [FFT_LEN_LOG2-1:0] s1_bin_q, s2_bin_q;
  logic                    s1_first_q, s1_last_q, s2_first_q, s2_last_q;
  logic [3:0]              s1_avg_q, s2_avg_q;
  logic [31:0]             s1_thr_q, s2_thr_q, s2_pow_q;
  logic [ACC_WIDTH-1:0]    rd_q;
  logic signed [31:0]      re_sq, im_sq;
  logic [31:0]             pow_d;

  assign re_sq = 32'(s1_re_q) * 32'(s1_re_q);
  assign im_sq = 32'(s1_im_q) * 32'(s1_im_q);
  assign pow_d = $unsigned(re_sq) + $unsigned(im_sq);

  // S1 capture and S2 power stage; resync drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;   s2_vld_q <= 1'b0;
      s1_re_q <= '0;      s1_im_q <= '0;
      s1_bin_q <= '0;     s2_bin_q <= '0;
      s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      s2_first_q <= 1'b0; s2_last_q <= 1'b0;
      s1_avg_q <= 4'd0;   s2_avg_q <= 4'd0;
      s1_thr_q <= 32'd0;  s2_thr_q <= 32'd0;
      s2_pow_q <= 32'd0;
    end else begin
      s1_vld_q <= strobe_in_i && !resync;
      s2_vld_q <= s1_vld_q && !resync;
      if (strobe_in_i) begin
        s1_re_q    <= xk_i[15:0];
        s1_im_q    <= xk_i[31:16];
        s1_bin_q   <= bin_cnt_q;
        s1_first_q <= first_eff;
        s1_last_q  <= last_eff;
        s1_avg_q   <= avg_eff;
        s1_thr_q   <= thr_eff;
      end
      if (s1_vld_q) begin
        s2_bin_q   <= s1_bin_q;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_avg_q   <= s1_avg_q;
        s2_thr_q   <= s1_thr_q;
        s2_pow_q   <= pow_d;
      end
    end
  end

  logic [ACC_WIDTH-1:0] mem [NBINS];
  logic [ACC_WIDTH-1:0] acc_d;
  logic [31:0]          avg_pwr_d;
  logic                 above_d, out_fire, bin_first, take_peak, any_d;
  logic [31:0]          run_max_q;
  logic [FFT_LEN_LOG2-1:0] run_bin_q;
  logic                 run_any_q;

  // S3 accumulate, average and running peak/any decisions.
  always_comb begin
    acc_d     = (s2_first_q ? '0 : rd_q) + ACC_WIDTH'(s2_pow_q);
    avg_pwr_d = 32'(acc_d >> s2_avg_q);
    above_d   = avg_pwr_d > s2_thr_q;
    out_fire  = s2_vld_q && s2_last_q && !resync;
    bin_first = (s2_bin_q == BIN_ZERO);
    take_peak = bin_first || (avg_pwr_d > run_max_q);
    any_d     = (bin_first ? 1'b0 : run_any_q) | above_d;
  end

  // Accumulator RAM: read issued from S1, write-back from S3.
  always_ff @(posedge clk_i) begin
    if (s2_vld_q && !resync) mem[s2_bin_q] <= acc_d;
    if (s1_vld_q) rd_q <= mem[s1_bin_q];
  end

  // Output stream, running trackers and per-period readback registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_out_o <= 1'b0;  power_out_o  <= 32'd0;
      bin_out_o    <= '0;    above_thr_o  <= 1'b0;
      frame_done_o <= 1'b0;  detect_o     <= 1'b0;
      peak_bin_o   <= '0;    peak_power_o <= 32'd0;
      run_max_q    <= 32'd0; run_bin_q    <= '0;
      run_any_q    <= 1'b0;
    end else begin
      strobe_out_o <= out_fire;
      frame_done_o <= out_fire && (s2_bin_q == BIN_LAST);
      if (out_fire) begin
        power_out_o <= avg_pwr_d;
        bin_out_o   <= s2_bin_q;
        above_thr_o <= above_d;
        run_any_q   <= any_d;
        if (take_peak) begin
          run_max_q <= avg_pwr_d;
          run_bin_q <= s2_bin_q;
        end
      end
      if (frame_done_o) begin
        peak_bin_o   <= run_bin_q;
        peak_power_o <= run_max_q;
        detect_o     <= run_any_q;
      end
    end
  end

endmodule

// File: tb/tb_fft_energy_detector.sv
// Directed bench for fft_energy_detector: stimulus pushes hand-computed
// expected outputs into a queue, a negedge monitor pops and compares.
module tb_fft_energy_detector;
  localparam logic [7:0] SRB = 8'd40;

  logic        clk, rst_n, set_stb, strobe_in;
  logic [7:0]  set_addr;
  logic [31:0] set_data, xk;
  logic        strobe_out_o, above_thr_o, frame_done_o, detect_o;
  logic [31:0] power_out_o, peak_power_o;
  logic [9:0]  bin_out_o, peak_bin_o;

  fft_energy_detector dut (
    .clk_i(clk), .rst_ni(rst_n), .set_stb_i(set_stb), .set_addr_i(set_addr),
    .set_data_i(set_data), .strobe_in_i(strobe_in), .xk_i(xk),
    .strobe_out_o(strobe_out_o), .power_out_o(power_out_o), .bin_out_o(bin_out_o),
    .above_thr_o(above_thr_o), .frame_done_o(frame_done_o), .detect_o(detect_o),
    .peak_bin_o(peak_bin_o), .peak_power_o(peak_power_o)
  );

  typedef struct {
    int          due;
    logic [31:0] pwr;
    logic [9:0]  bin;
    logic        abv;
    logic        fd;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] re_a [1024];
  logic [15:0] im_a [1024];
  logic [31:0] exp_pwr [1024];
  logic        exp_abv [1024];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, expv);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done_o && !strobe_out_o) begin
        n_checks++;
        $display("FAIL frame_done_alone: frame_done=1 with strobe_out=0, required strobe_out=1");
      end
      if (strobe_out_o) begin
        n_checks++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_strobe: cyc=%0d bin_out=%0d power_out=%0h, required no strobe_out",
                   cyc, bin_out_o, power_out_o);
        end else begin
          mon_e = sbq.pop_front();
          if (cyc == mon_e.due && power_out_o == mon_e.pwr && bin_out_o == mon_e.bin &&
              above_thr_o == mon_e.abv && frame_done_o == mon_e.fd)
            n_pass++;
          else
            $display("FAIL out_vec: got cyc=%0d pwr=%0h bin=%0d abv=%0b fd=%0b, required cyc=%0d pwr=%0h bin=%0d abv=%0b fd=%0b",
                     cyc, power_out_o, bin_out_o, above_thr_o, frame_done_o,
                     mon_e.due, mon_e.pwr, mon_e.bin, mon_e.abv, mon_e.fd);
        end
      end
    end
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im, input bit push,
                      input logic [31:0] ep, input logic [9:0] eb, input logic ea, input logic efd);
    @(posedge clk); #1;
    set_stb   = 1'b0;
    strobe_in = 1'b1;
    xk        = {im, re};
    if (push) sbq.push_back('{due: cyc + 3, pwr: ep, bin: eb, abv: ea, fd: efd});
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    strobe_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    strobe_in = 1'b0;
    set_stb   = 1'b1;
    set_addr  = a;
    set_data  = d;
    @(posedge clk); #1;
    set_stb   = 1'b0;
  endtask

  task automatic fill_frame(input logic [15:0] re, input logic [15:0] im,
                            input logic [31:0] ep, input logic ea);
    for (int b = 0; b < 1024; b++) begin
      re_a[b] = re; im_a[b] = im; exp_pwr[b] = ep; exp_abv[b] = ea;
    end
  endtask

  task automatic run_frame(input bit push);
    for (int b = 0; b < 1024; b++)
      send(re_a[b], im_a[b], push, exp_pwr[b], 10'(b), exp_abv[b], b == 1023);
  endtask

  task automatic chk_peak(input string tag, input logic det, input logic [9:0] pb, input logic [31:0] pp);
    chk({tag, "_detect"}, 64'(detect_o), 64'(det));
    chk({tag, "_peak_bin"}, 64'(peak_bin_o), 64'(pb));
    chk({tag, "_peak_power"}, 64'(peak_power_o), 64'(pp));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_strobe_out"}, 64'(strobe_out_o), 64'd0);
    chk({tag, "_power_out"}, 64'(power_out_o), 64'd0);
    chk({tag, "_bin_out"}, 64'(bin_out_o), 64'd0);
    chk({tag, "_above_thr"}, 64'(above_thr_o), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done_o), 64'd0);
    chk_peak(tag, 1'b0, 10'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    strobe_in = 1'b0; xk = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("reset");

    // avg_log2=0, threshold=0: every bin 3,4 -> 25, latency 3, ties keep bin 0
    fill_frame(16'd3, 16'd4, 32'd25, 1'b1);
    run_frame(1'b1);
    idle(8);
    chk_peak("uniform", 1'b1, 10'd0, 32'd25);

    // full-scale corner on bin 5: (-32768)^2 * 2 = 0x80000000
    fill_frame(16'd1, 16'd1, 32'd2, 1'b1);
    re_a[5] = 16'h8000; im_a[5] = 16'h8000; exp_pwr[5] = 32'h8000_0000;
    run_frame(1'b1);
    idle(8);
    chk_peak("fullscale", 1'b1, 10'd5, 32'h8000_0000);

    // threshold=24: bins 100/200 at 50, rest 9; tie keeps bin 100
    set_write(SRB + 8'd1, 32'd24);
    fill_frame(16'd3, 16'd0, 32'd9, 1'b0);
    re_a[100] = 16'd5; im_a[100] = 16'd5; exp_pwr[100] = 32'd50; exp_abv[100] = 1'b1;
    re_a[200] = 16'd1; im_a[200] = 16'd7; exp_pwr[200] = 32'd50; exp_abv[200] = 1'b1;
    run_frame(1'b1);
    idle(8);
    chk_peak("thresh", 1'b1, 10'd100, 32'd50);

    // avg_log2=2: bin 7 = 10,20,25,45 -> 25; bin 9 = 1,1,1,2 -> 1; rest 4
    set_write(SRB, 32'd2);
    for (int f = 0; f < 4; f++) begin
      fill_frame(16'd2, 16'd0, 32'd4, 1'b0);
      case (f)
        0: begin re_a[7] = 16'd1; im_a[7] = 16'd3; end
        1: begin re_a[7] = 16'd2; im_a[7] = 16'd4; end
        2: begin re_a[7] = 16'd3; im_a[7] = 16'd4; end
        default: begin re_a[7] = 16'd3; im_a[7] = 16'd6; end
      endcase
      re_a[9] = 16'd1; im_a[9] = (f == 3) ? 16'd1 : 16'd0;
      exp_pwr[7] = 32'd25; exp_abv[7] = 1'b1; exp_pwr[9] = 32'd1;
      run_frame(f == 3);
    end
    idle(8);
    chk_peak("avg4", 1'b1, 10'd7, 32'd25);

    // avg_log2=1 written after frame 0: this period still 4 frames (bin 3 ->
    // (4+16+36+64)/4 = 30), the next one 2 frames (bin 3 -> (4+16)/2 = 10)
    for (int f = 0; f < 4; f++) begin
      fill_frame(16'd2, 16'd0, 32'd4, 1'b0);
      re_a[3] = 16'(2 * (f + 1)); exp_pwr[3] = 32'd30; exp_abv[3] = 1'b1;
      run_frame(f == 3);
      if (f == 0) set_write(SRB, 32'd1);
    end
    idle(8);
    chk_peak("shadow_old", 1'b1, 10'd3, 32'd30);
    for (int f = 0; f < 2; f++) begin
      fill_frame(16'd2, 16'd0, 32'd4, 1'b0);
      re_a[3] = 16'(2 * (f + 1)); exp_pwr[3] = 32'd10;
      run_frame(f == 1);
    end
    idle(8);
    chk_peak("shadow_new", 1'b0, 10'd3, 32'd10);

    // resync mid-frame: last two in-flight bins dropped, readback held,
    // next strobe is bin 0
    set_write(SRB, 32'd0);
    for (int b = 0; b < 50; b++) send(16'd1, 16'd0, b <= 47, 32'd1, 10'(b), 1'b0, 1'b0);
    set_write(SRB + 8'd2, 32'hDEAD_BEEF);
    idle(6);
    chk_peak("resync_hold", 1'b0, 10'd3, 32'd10);
    fill_frame(16'd1, 16'd0, 32'd1, 1'b0);
    re_a[0] = 16'd7; exp_pwr[0] = 32'd49; exp_abv[0] = 1'b1;
    run_frame(1'b1);
    idle(8);
    chk_peak("resync_frame", 1'b1, 10'd0, 32'd49);

    // async reset mid-frame: outputs clear without a clock edge
    for (int b = 0; b < 30; b++) send(16'd1, 16'd0, 1'b1, 32'd1, 10'(b), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    strobe_in = 1'b0;
    sbq.delete();
    #1 chk_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_frame(16'd3, 16'd4, 32'd25, 1'b1);
    run_frame(1'b1);
    idle(10);
    chk_peak("post_reset", 1'b1, 10'd0, 32'd25);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
